// File: rtl/riscv_enc_pkg.sv
// Shared types and RV32I field constants for the
// instruction encoder and program loader.
package riscv_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_ADDI, OP_SLTI, OP_SLLI, OP_SRAI,
    OP_LW, OP_SW, OP_BEQ, OP_JAL
  } op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OP   = 2'b01;
  localparam logic [1:0] ERR_IMM  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder: symbolic op and fields
// to a 32-bit word, with illegal-op and immediate-range flags.
module instr_encode
  import riscv_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal_op,
  output logic        imm_bad
);

  logic signed [20:0] simm;
  logic i_ok;
  logic b_ok;

  assign simm = $signed(imm);
  assign i_ok = (simm >= -21'sd2048)
             && (simm <= 21'sd2047);
  assign b_ok = (simm >= -21'sd4096)
             && (simm <= 21'sd4094)
             && !imm[0];

  always_comb begin
    word       = '0;
    illegal_op = 1'b0;
    imm_bad    = 1'b0;
    unique case (op)
      OP_ADD:
        word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_R};
      OP_SUB:
        word = {F7_ALT, rs2, rs1, F3_ADD, rd, OPC_R};
      OP_AND:
        word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_R};
      OP_OR:
        word = {F7_BASE, rs2, rs1, F3_OR, rd, OPC_R};
      OP_SLT:
        word = {F7_BASE, rs2, rs1, F3_SLT, rd, OPC_R};
      OP_ADDI: begin
        word = {imm[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
        imm_bad = !i_ok;
      end
      OP_SLTI: begin
        word = {imm[11:0], rs1, F3_SLT, rd, OPC_OPIMM};
        imm_bad = !i_ok;
      end
      OP_SLLI: begin
        word = {F7_BASE, imm[4:0], rs1, F3_SLL,
                rd, OPC_OPIMM};
        imm_bad = |imm[20:5];
      end
      OP_SRAI: begin
        word = {F7_ALT, imm[4:0], rs1, F3_SR,
                rd, OPC_OPIMM};
        imm_bad = |imm[20:5];
      end
      OP_LW: begin
        word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
        imm_bad = !i_ok;
      end
      OP_SW: begin
        word = {imm[11:5], rs2, rs1, F3_SW,
                imm[4:0], OPC_STORE};
        imm_bad = !i_ok;
      end
      OP_BEQ: begin
        word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                imm[4:1], imm[11], OPC_BRANCH};
        imm_bad = !b_ok;
      end
      OP_JAL: begin
        // every even 21-bit value is a legal offset
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, OPC_JAL};
        imm_bad = imm[0];
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Streams symbolic instructions through the encoder and
// writes them to consecutive instruction-memory words.
module imem_program_loader
  import riscv_enc_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_ill;
  logic              enc_bad;

  instr_encode u_enc (
    .op         (in_op),
    .rd         (in_rd),
    .rs1        (in_rs1),
    .rs2        (in_rs2),
    .imm        (in_imm),
    .word       (enc_word),
    .illegal_op (enc_ill),
    .imm_bad    (enc_bad)
  );

  assign busy     = (state == ST_LOAD);
  assign in_ready = busy;
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_code  <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (enc_ill) begin
              state    <= ST_ERR;
              err_code <= ERR_OP;
            end else if (enc_bad) begin
              state    <= ST_ERR;
              err_code <= ERR_IMM;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= enc_word;
              count     <= count + CNT_ONE;
              // top word is still written; pointer never wraps
              if (in_last) begin
                state <= ST_DONE;
              end else if (ptr == PTR_MAX) begin
                state    <= ST_ERR;
                err_code <= ERR_OVF;
              end else begin
                ptr <= ptr + PTR_ONE;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state    <= ST_LOAD;
            ptr      <= base_addr;
            count    <= '0;
            err_code <= ERR_NONE;
          end
        end
      endcase
    end
  end

endmodule
